// File: rtl/mult_pkg.sv
// Shared constants and types for the multiplier / accumulator pair.
// Product width is fixed by the multiplier; LEN and DEPTH are defaults that
// instantiating modules may override.
package mult_pkg;

    localparam int PROD_W        = 8;
    localparam int DEFAULT_LEN   = 4;
    localparam int DEFAULT_DEPTH = 4;

    // Sum of len products of prodW bits each can never exceed this width
    function automatic int acc_width(input int prodW, input int len);
        return prodW + $clog2(len);
    endfunction

    localparam int ACC_W = acc_width(PROD_W, DEFAULT_LEN);

    typedef logic [ACC_W-1:0] acc_t;

endpackage

// File: rtl/mult_acc_fifo.sv
// Small synchronous FIFO holding completed sums.
// A push while full is accepted only when a pop frees the head slot in the
// same cycle; otherwise it is silently refused and the caller flags the loss.
// The head is read combinationally from storage and forced to 0 when empty.
module mult_acc_fifo
    import mult_pkg::*;
#(
    parameter int WIDTH = 10,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rstn,
    input  logic                     push_i,
    input  logic                     pop_i,
    input  logic                     clear_i,
    input  logic [WIDTH-1:0]         data_i,
    output logic [WIDTH-1:0]         head_o,
    output logic [$clog2(DEPTH):0]   level_o,
    output logic                     full_o,
    output logic                     empty_o
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int LVL_W = PTR_W + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [LVL_W-1:0] level_q, level_d;
    logic             do_push;
    logic             do_pop;

    // Qualify push/pop and compute next pointers and level; clear wins over both
    always_comb begin
        full_o   = (level_q == LVL_W'(DEPTH));
        empty_o  = (level_q == '0);
        do_push  = push_i & (~full_o | pop_i) & ~clear_i;
        do_pop   = pop_i & ~empty_o & ~clear_i;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        level_d  = level_q;
        if (clear_i) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            level_d  = '0;
        end else begin
            if (do_push) begin
                wr_ptr_d = wr_ptr_q + PTR_W'(1);
            end
            if (do_pop) begin
                rd_ptr_d = rd_ptr_q + PTR_W'(1);
            end
            case ({do_push, do_pop})
                2'b10:   level_d = level_q + LVL_W'(1);
                2'b01:   level_d = level_q - LVL_W'(1);
                default: level_d = level_q;
            endcase
        end
    end

    // Pointer and level registers
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
        end
    end

    // Storage needs no reset because the head is masked while empty
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= data_i;
        end
    end

    // Head entry, 0 when nothing is held
    always_comb begin
        head_o  = empty_o ? '0 : mem_q[rd_ptr_q];
        level_o = level_q;
    end

endmodule

// File: rtl/mult_accumulator.sv
// Sums every LEN consecutive products from the multiplier stream and queues
// each finished sum in a small FIFO. The multiplier cannot stall, so input is
// never back-pressured; a sum that finds the FIFO full with no pop is dropped
// and recorded in a sticky overflow flag.
module mult_accumulator
    import mult_pkg::*;
#(
    parameter int PROD_W = mult_pkg::PROD_W,
    parameter int LEN    = mult_pkg::DEFAULT_LEN,
    parameter int ACC_W  = mult_pkg::acc_width(PROD_W, LEN),
    parameter int DEPTH  = mult_pkg::DEFAULT_DEPTH
) (
    input  logic                     clk,
    input  logic                     rstn,
    input  logic                     res_rdy,
    input  logic [PROD_W-1:0]        res,
    input  logic                     clear,
    output logic                     acc_valid,
    input  logic                     acc_ready,
    output logic [ACC_W-1:0]         acc_sum,
    output logic [$clog2(DEPTH):0]   fifo_level,
    output logic                     overflow,
    output logic                     partial
);

    localparam int CNT_W = $clog2(LEN);

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [ACC_W-1:0] acc_q, acc_d;
    logic             overflow_q, overflow_d;
    logic [ACC_W-1:0] sum;
    logic             beat;
    logic             last;
    logic             push;
    logic             pop;
    logic             fifo_full;
    logic             fifo_empty;

    // Beat counting, running sum, push/pop generation and sticky overflow
    always_comb begin
        beat       = res_rdy & ~clear;
        last       = (cnt_q == CNT_W'(LEN - 1));
        sum        = ((cnt_q == '0) ? '0 : acc_q) + ACC_W'(res);
        push       = beat & last;
        pop        = ~fifo_empty & acc_ready & ~clear;
        cnt_d      = cnt_q;
        acc_d      = acc_q;
        overflow_d = overflow_q;
        if (clear) begin
            cnt_d      = '0;
            acc_d      = '0;
            overflow_d = 1'b0;
        end else begin
            if (beat) begin
                cnt_d = last ? '0 : cnt_q + CNT_W'(1);
                acc_d = sum;
            end
            if (push && fifo_full && !pop) begin
                overflow_d = 1'b1;
            end
        end
    end

    // Group state registers
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            cnt_q      <= '0;
            acc_q      <= '0;
            overflow_q <= 1'b0;
        end else begin
            cnt_q      <= cnt_d;
            acc_q      <= acc_d;
            overflow_q <= overflow_d;
        end
    end

    mult_acc_fifo #(
        .WIDTH (ACC_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rstn    (rstn),
        .push_i  (push),
        .pop_i   (pop),
        .clear_i (clear),
        .data_i  (sum),
        .head_o  (acc_sum),
        .level_o (fifo_level),
        .full_o  (fifo_full),
        .empty_o (fifo_empty)
    );

    // Status outputs
    always_comb begin
        acc_valid = ~fifo_empty;
        overflow  = overflow_q;
        partial   = (cnt_q != '0);
    end

endmodule

// File: tb/tb_mult_accumulator.sv
// Directed testbench for mult_accumulator with LEN=4, DEPTH=4, PROD_W=8.
module tb_mult_accumulator;

    logic       clk;
    logic       rstn;
    logic       resRdy;
    logic [7:0] res;
    logic       clear;
    logic       accValid;
    logic       accReady;
    logic [9:0] accSum;
    logic [2:0] fifoLevel;
    logic       overflow;
    logic       partial;

    int numChecks;
    int numFails;

    mult_accumulator dut (
        .clk        (clk),
        .rstn       (rstn),
        .res_rdy    (resRdy),
        .res        (res),
        .clear      (clear),
        .acc_valid  (accValid),
        .acc_ready  (accReady),
        .acc_sum    (accSum),
        .fifo_level (fifoLevel),
        .overflow   (overflow),
        .partial    (partial)
    );

    // Free-running clock, rising edges at 5, 15, 25, ...
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Drive one cycle of inputs, clock it, then settle 1 time unit past the edge
    task automatic applyStimulus(input logic rdy, input logic [7:0] prod,
                                 input logic ready, input logic clr);
        resRdy   = rdy;
        res      = prod;
        accReady = ready;
        clear    = clr;
        @(posedge clk);
        #1;
    endtask

    // Single comparison point
    task automatic checkOne(input string tag, input logic [31:0] observed,
                            input logic [31:0] expected);
        numChecks++;
        assert (observed === expected) else begin
            numFails++;
            $error("[TB] FAIL %s: observed %0d expected %0d", tag, observed, expected);
        end
    endtask

    // Compare every observable output against the hand-computed values
    task automatic checkOutput(input string tag, input int expValid, input int expSum,
                               input int expLevel, input int expOverflow,
                               input int expPartial);
        checkOne({tag, ".acc_valid"},  32'(accValid),  32'(expValid));
        checkOne({tag, ".acc_sum"},    32'(accSum),    32'(expSum));
        checkOne({tag, ".fifo_level"}, 32'(fifoLevel), 32'(expLevel));
        checkOne({tag, ".overflow"},   32'(overflow),  32'(expOverflow));
        checkOne({tag, ".partial"},    32'(partial),   32'(expPartial));
    endtask

    initial begin
        numChecks = 0;
        numFails  = 0;
        rstn      = 1'b0;
        resRdy    = 1'b0;
        res       = 8'd0;
        clear     = 1'b0;
        accReady  = 1'b0;

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        checkOutput("reset", 0, 0, 0, 0, 0);
        #2 rstn = 1'b1;

        // Basic sum: 4 x 225 = 900
        applyStimulus(1, 8'd225, 1, 0);
        checkOutput("basic.b1", 0, 0, 0, 0, 1);
        applyStimulus(1, 8'd225, 1, 0);
        checkOutput("basic.b2", 0, 0, 0, 0, 1);
        applyStimulus(1, 8'd225, 1, 0);
        checkOutput("basic.b3", 0, 0, 0, 0, 1);
        applyStimulus(1, 8'd225, 1, 0);
        checkOutput("basic.b4", 1, 900, 1, 0, 0);
        applyStimulus(0, 8'd0, 1, 0);
        checkOutput("basic.pop", 0, 0, 0, 0, 0);

        // Gapped input: 1,2,3,4 with 0, 1 and 3 idle cycles between beats
        applyStimulus(1, 8'd1, 1, 0);
        checkOutput("gap.b1", 0, 0, 0, 0, 1);
        applyStimulus(1, 8'd2, 1, 0);
        checkOutput("gap.b2", 0, 0, 0, 0, 1);
        applyStimulus(0, 8'd99, 1, 0);
        checkOutput("gap.idle1", 0, 0, 0, 0, 1);
        applyStimulus(1, 8'd3, 1, 0);
        checkOutput("gap.b3", 0, 0, 0, 0, 1);
        for (int i = 0; i < 3; i++) begin
            applyStimulus(0, 8'd77, 1, 0);
            checkOutput("gap.idle3", 0, 0, 0, 0, 1);
        end
        applyStimulus(1, 8'd4, 1, 0);
        checkOutput("gap.b4", 1, 10, 1, 0, 0);
        applyStimulus(0, 8'd0, 1, 0);
        checkOutput("gap.pop", 0, 0, 0, 0, 0);

        // Backpressure: five groups of 1,1,1,1 with no consumer
        for (int g = 1; g <= 5; g++) begin
            for (int b = 0; b < 4; b++) begin
                applyStimulus(1, 8'd1, 0, 0);
            end
            if (g <= 4) begin
                checkOutput("ovf.fill", 1, 4, g, 0, 0);
            end else begin
                checkOutput("ovf.drop", 1, 4, 4, 1, 0);
            end
        end
        for (int i = 3; i >= 0; i--) begin
            applyStimulus(0, 8'd0, 1, 0);
            checkOutput("ovf.drain", (i != 0) ? 1 : 0, (i != 0) ? 4 : 0, i, 1, 0);
        end
        applyStimulus(0, 8'd0, 0, 1);
        checkOutput("ovf.clear", 0, 0, 0, 0, 0);

        // Full FIFO with push and pop in the same cycle
        for (int g = 1; g <= 4; g++) begin
            for (int b = 0; b < 4; b++) begin
                applyStimulus(1, 8'(g), 0, 0);
            end
            checkOutput("full.fill", 1, 4, g, 0, 0);
        end
        for (int b = 0; b < 3; b++) begin
            applyStimulus(1, 8'd5, 0, 0);
            checkOutput("full.g5", 1, 4, 4, 0, 1);
        end
        applyStimulus(1, 8'd5, 1, 0);
        checkOutput("full.pushpop", 1, 8, 4, 0, 0);
        applyStimulus(0, 8'd0, 1, 0);
        checkOutput("full.drain1", 1, 12, 3, 0, 0);
        applyStimulus(0, 8'd0, 1, 0);
        checkOutput("full.drain2", 1, 16, 2, 0, 0);
        applyStimulus(0, 8'd0, 1, 0);
        checkOutput("full.drain3", 1, 20, 1, 0, 0);
        applyStimulus(0, 8'd0, 1, 0);
        checkOutput("full.drain4", 0, 0, 0, 0, 0);

        // Clear mid-group overrides a simultaneous beat
        applyStimulus(1, 8'd100, 1, 0);
        checkOutput("clr.b1", 0, 0, 0, 0, 1);
        applyStimulus(1, 8'd100, 1, 0);
        checkOutput("clr.b2", 0, 0, 0, 0, 1);
        applyStimulus(1, 8'd50, 1, 1);
        checkOutput("clr.clear", 0, 0, 0, 0, 0);
        for (int b = 0; b < 3; b++) begin
            applyStimulus(1, 8'd1, 1, 0);
            checkOutput("clr.beat", 0, 0, 0, 0, 1);
        end
        applyStimulus(1, 8'd1, 1, 0);
        checkOutput("clr.sum", 1, 4, 1, 0, 0);
        applyStimulus(0, 8'd0, 1, 0);
        checkOutput("clr.pop", 0, 0, 0, 0, 0);

        // Asynchronous reset with two entries queued and cnt=2
        for (int g = 0; g < 2; g++) begin
            for (int b = 0; b < 4; b++) begin
                applyStimulus(1, 8'd3, 0, 0);
            end
        end
        applyStimulus(1, 8'd3, 0, 0);
        applyStimulus(1, 8'd3, 0, 0);
        checkOutput("rst.before", 1, 12, 2, 0, 1);
        resRdy = 1'b0;
        #2 rstn = 1'b0;
        #1;
        checkOutput("rst.async", 0, 0, 0, 0, 0);
        #2 rstn = 1'b1;
        applyStimulus(0, 8'd0, 1, 0);
        checkOutput("rst.idle", 0, 0, 0, 0, 0);
        for (int b = 0; b < 3; b++) begin
            applyStimulus(1, 8'd7, 1, 0);
            checkOutput("rst.beat", 0, 0, 0, 0, 1);
        end
        applyStimulus(1, 8'd7, 1, 0);
        checkOutput("rst.sum", 1, 28, 1, 0, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", numChecks, numFails);
        $finish;
    end

endmodule

// File: doc/mult_accumulator.md
# mult_accumulator

Downstream consumer of `pipelined_multiplier`. It takes the multiplier's `res_rdy`/`res` product stream, sums every group of LEN consecutive products into a wider accumulator, and buffers each finished sum in a small FIFO. The sums are presented on a valid/ready output port. The multiplier cannot be stalled, so this block never back-pressures its input and reports lost sums through a sticky flag.

## Interface
- `PROD_W`, 8: product width; matches multiplier `res`.
- `LEN`, 4: products per sum; range 2..16.
- `ACC_W`, `PROD_W + $clog2(LEN)` (10): sum width; no overflow is possible.
- `DEPTH`, 4: output FIFO entries; power of two, ≥2.

Ports:
- `clk`  in  1  single clock, rising edge.
- `rstn`  in  1  asynchronous, active-low reset.
- `res_rdy`  in  1  product valid, from the multiplier.
- `res`  in  PROD_W  product, from the multiplier.
- `clear`  in  1  synchronous flush of the count, accumulator, FIFO and overflow flag.
- `acc_valid`  out  1  FIFO non-empty.
- `acc_ready`  in  1  consumer accepts the head entry.
- `acc_sum`  out  ACC_W  FIFO head entry; 0 when empty.
- `fifo_level`  out  $clog2(DEPTH)+1  number of entries held.
- `overflow`  out  1  sticky: a completed sum was dropped.
- `partial`  out  1  `cnt != 0` (a sum is in progress).

## Operation
- **Beat counter `cnt`:**
  - Range 0..LEN-1; advances only on `res_rdy`.
  - At LEN-1 it wraps to 0 and a push is generated.
  - Gaps in `res_rdy` of any length are allowed; the group simply resumes.
- **Accumulator `acc` (ACC_W bits), on `res_rdy`:**
  - When `cnt==0`: `acc <= zext(res)`.
  - Otherwise: `acc <= acc + zext(res)`.
- **Push value:** `acc + zext(res)` on the LEN-th beat, i.e. the completed sum, bypassing the `acc` register.
- **Pop:** occurs when `acc_valid && acc_ready`; the head advances.
- **Push while full:**
  - With a pop in the same cycle: the push is accepted and the level is unchanged.
  - Without a pop: the sum is discarded, `overflow` is set, and FIFO contents and level are unchanged.
- **Push and pop together at any level:** the level is unchanged; data order is preserved.
- **`clear`:**
  - On the next edge: `cnt=0`, `acc=0`, FIFO empty, `overflow=0`.
  - It has priority over `res_rdy`, push and pop in the same cycle; that beat is ignored and that pop has no effect.
- **`acc_ready` while empty:** no effect.
- **`overflow`:** cleared only by `clear` or reset.

## Timing
- **Reset values (asynchronous, immediately on `rstn` low):** `acc_valid=0`, `acc_sum=0`, `fifo_level=0`, `overflow=0`, `partial=0`; internal `cnt=0`, `acc=0`, pointers 0.
- **Latency:** LEN-th beat at edge t → `acc_valid=1` with the sum after edge t (cycle t+1), provided the FIFO was empty.
- **Head output:** `acc_sum` is driven combinationally from registered FIFO storage at the read pointer. There is no extra output register.
- **Throughput:**
  - Accepts one product every cycle indefinitely.
  - Sustains one pop per cycle.
  - Sustained rate: one sum per LEN cycles.
- **Reset mid-group or with FIFO non-empty:** all state is lost; the first beat after reset release starts a new group.
- **Pointers and level:**
  - Pointers wrap modulo DEPTH.
  - Level counts 0..DEPTH; full when the level equals DEPTH.

## Structure
- **Package `mult_pkg`:** `PROD_W`, default `LEN`/`DEPTH`, `acc_t` (logic [ACC_W-1:0]) and the `ACC_W` derivation function. It is shared with `pipelined_multiplier` wrappers.
- **Sub-module `mult_acc_fifo`:** synchronous FIFO, parameters width/depth.
  - Ports: push, pop, clear, data in, head out, level, full, empty.
  - It implements the push-when-full-with-pop rule.
- **Top level:** `cnt`, `acc`, push generation, overflow flag and `partial` logic.

## Test plan
- **Basic sum:** reset; with `acc_ready=1`, feed `res=225` on 4 consecutive cycles. Required: `acc_valid` for 1 cycle, one cycle after the 4th beat, with `acc_sum=900`; `partial` reads 1,1,1,0 over the beats.
- **Gapped input:** feed 1,2,3,4 with 0–3 idle cycles between beats. Required: `acc_sum=10`; `partial` stays 1 across the gaps.
- **Backpressure and overflow:**
  - Hold `acc_ready=0` and complete 5 groups of products 1,1,1,1. Required: `fifo_level=4`, `overflow=1` after the 5th group; draining yields four sums of 4, then `acc_valid=0`.
  - Then `clear`. Required: `overflow=0`.
- **Full with simultaneous push/pop:** fill to 4 with sums 4,8,12,16, then complete sum 20 in the cycle `acc_ready` rises. Required: level stays 4, `overflow=0`, drain order 8,12,16,20.
- **`clear` mid-group:** 2 beats of 100, then `clear` with `res_rdy=1`, `res=50`, then beats 1,1,1,1. Required: single output `acc_sum=4`.
- **Asynchronous reset mid-operation:** assert `rstn=0` between edges with 2 entries queued and `cnt=2`. Required: all outputs 0 immediately; after release, 4 beats of 7 → `acc_sum=28`.
